// File: rtl/ad9122_spi_pkg.sv
// Shared constants, reset defaults and small helpers for the AD9122 SPI responder model.
package ad9122_spi_pkg;

  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 128;

  localparam logic [3:0] RW_BIT    = 4'd0;
  localparam logic [3:0] ADDR_LAST = 4'd7;
  localparam logic [3:0] DATA_LAST = 4'd15;

  // Power-on contents; 0x1F mirrors the chip ID so a raw array dump is consistent.
  localparam logic [DATA_W-1:0] REG_DEFAULTS [0:NUM_REGS-1] = '{
    7'h01:   8'h40,
    7'h03:   8'h02,
    7'h12:   8'h5A,
    7'h1F:   8'h08,
    7'h20:   8'hC3,
    7'h7F:   8'h81,
    default: 8'h00
  };

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_rec_t;

  // Serial read byte bit presented while bit_cnt sits at cnt (8 -> D7 ... 15 -> D0).
  function automatic logic [2:0] rd_bit_sel(input logic [3:0] cnt);
    return 3'(DATA_LAST - cnt);
  endfunction

endpackage

// File: rtl/ad9122_regfile.sv
// 128x8 register file with one write port, serial and debug read ports and default reload.
module ad9122_regfile
  import ad9122_spi_pkg::*;
#(
  parameter logic [7:0] CHIP_ID      = 8'h08,
  parameter logic [6:0] CHIP_ID_ADDR = 7'h1F,
  parameter int         SOFT_RST_BIT = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                reload,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [ADDR_W-1:0]   ser_addr,
  output logic [DATA_W-1:0]   ser_data,
  input  logic [ADDR_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0]   dbg_data
);

  localparam logic [DATA_W-1:0] SRST_MASK = 8'(8'd1 << SOFT_RST_BIT);

  logic [DATA_W-1:0] mem_r [0:NUM_REGS-1];

  // Storage: defaults on reset, defaults with the soft-reset bit cleared on reload, else writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= REG_DEFAULTS[i];
      end
    end else if (reload) begin
      mem_r[0] <= REG_DEFAULTS[0] & ~SRST_MASK;
      for (int i = 1; i < NUM_REGS; i++) begin
        mem_r[i] <= REG_DEFAULTS[i];
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read ports; the chip-ID location is hard-wired regardless of array contents.
  always_comb begin
    ser_data = mem_r[ser_addr];
    dbg_data = mem_r[dbg_addr];
    if (ser_addr == CHIP_ID_ADDR) begin
      ser_data = CHIP_ID;
    end else begin
      ser_data = mem_r[ser_addr];
    end
    if (dbg_addr == CHIP_ID_ADDR) begin
      dbg_data = CHIP_ID;
    end else begin
      dbg_data = mem_r[dbg_addr];
    end
  end

endmodule

// File: rtl/ad9122_spi_slave_model.sv
// AD9122 3-wire SPI responder: decodes R/W + 7-bit address + 8-bit data words MSB first,
// commits writes to a 128x8 register file and returns read data on the falling edge.
module ad9122_spi_slave_model
  import ad9122_spi_pkg::*;
#(
  parameter logic [7:0] CHIP_ID      = 8'h08,
  parameter logic [6:0] CHIP_ID_ADDR = 7'h1F,
  parameter int         SOFT_RST_BIT = 5
) (
  input  logic                o_sclk,
  input  logic                rst_n,
  input  logic                i_sen_n,
  input  logic                i_sda,
  output logic                o_sdo,
  output logic                o_sdo_oe,
  output logic                o_wr_toggle,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  input  logic [ADDR_W-1:0]   i_dbg_addr,
  output logic [DATA_W-1:0]   o_dbg_data
);

  logic                clr_n_s;
  logic [3:0]          bit_cnt_r;
  logic [6:0]          shift_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                rw_r;
  logic [DATA_W-1:0]   rd_byte_r;
  logic [ADDR_W-1:0]   ser_addr_s;
  logic [DATA_W-1:0]   ser_data_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic                commit_s;
  logic                srst_hit_s;
  logic                srst_pend_r;
  logic                wr_toggle_r;
  wr_rec_t             wr_rec_r;

  // Transaction state is dropped whenever the chip is deselected, not only on reset.
  assign clr_n_s    = rst_n & ~i_sen_n;
  assign ser_addr_s = {shift_r[5:0], i_sda};
  assign wr_data_s  = {shift_r, i_sda};

  // Commit decode at the last data edge; the chip-ID location is read-only.
  always_comb begin
    commit_s   = 1'b0;
    srst_hit_s = 1'b0;
    if ((bit_cnt_r == DATA_LAST) && !rw_r && (addr_r != CHIP_ID_ADDR)) begin
      commit_s   = 1'b1;
      srst_hit_s = (addr_r == 7'h00) && wr_data_s[SOFT_RST_BIT];
    end else begin
      commit_s   = 1'b0;
      srst_hit_s = 1'b0;
    end
  end

  // Rising-edge capture of R/W, address and data bits; read byte latched at the last address bit.
  always_ff @(posedge o_sclk or negedge clr_n_s) begin
    if (!clr_n_s) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= 7'd0;
      addr_r    <= 7'd0;
      rw_r      <= 1'b0;
      rd_byte_r <= 8'd0;
    end else begin
      bit_cnt_r <= bit_cnt_r + 4'd1;
      shift_r   <= ser_addr_s;
      if (bit_cnt_r == RW_BIT) begin
        rw_r <= i_sda;
      end
      if (bit_cnt_r == ADDR_LAST) begin
        addr_r <= ser_addr_s;
        if (rw_r) begin
          rd_byte_r <= ser_data_s;
        end
      end
    end
  end

  // Falling-edge read data drive during the data phase of a read word.
  always_ff @(negedge o_sclk or negedge clr_n_s) begin
    if (!clr_n_s) begin
      o_sdo    <= 1'b0;
      o_sdo_oe <= 1'b0;
    end else if (rw_r && bit_cnt_r[3]) begin
      o_sdo    <= rd_byte_r[rd_bit_sel(bit_cnt_r)];
      o_sdo_oe <= 1'b1;
    end else begin
      o_sdo    <= 1'b0;
      o_sdo_oe <= 1'b0;
    end
  end

  // Committed-write report and one-edge-delayed soft reset request.
  always_ff @(posedge o_sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_toggle_r <= 1'b0;
      wr_rec_r    <= '0;
      srst_pend_r <= 1'b0;
    end else begin
      srst_pend_r <= srst_hit_s;
      if (commit_s) begin
        wr_toggle_r <= ~wr_toggle_r;
        wr_rec_r    <= '{addr: addr_r, data: wr_data_s};
      end
    end
  end

  assign o_wr_toggle = wr_toggle_r;
  assign o_wr_addr   = wr_rec_r.addr;
  assign o_wr_data   = wr_rec_r.data;

  ad9122_regfile #(
    .CHIP_ID      (CHIP_ID),
    .CHIP_ID_ADDR (CHIP_ID_ADDR),
    .SOFT_RST_BIT (SOFT_RST_BIT)
  ) u_regfile (
    .clk      (o_sclk),
    .rst_n    (rst_n),
    .reload   (srst_pend_r),
    .we       (commit_s),
    .waddr    (addr_r),
    .wdata    (wr_data_s),
    .ser_addr (ser_addr_s),
    .ser_data (ser_data_s),
    .dbg_addr (i_dbg_addr),
    .dbg_data (o_dbg_data)
  );

endmodule

// File: tb/tb_ad9122_spi_slave_model.sv
// Directed bench for the AD9122 SPI responder; expected read bytes and write records go
// through scoreboard queues and are popped when the transfer completes.
module tb_ad9122_spi_slave_model;

  logic       o_sclk = 1'b0;
  logic       rst_n;
  logic       i_sen_n;
  logic       i_sda;
  logic       o_sdo;
  logic       o_sdo_oe;
  logic       o_wr_toggle;
  logic [6:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic [6:0] i_dbg_addr;
  logic [7:0] o_dbg_data;

  int n_checks = 0;
  int n_errors = 0;
  int tog_edges = 0;

  logic [7:0]  rd_q [$];
  logic [14:0] wr_q [$];

  ad9122_spi_slave_model dut (
    .o_sclk      (o_sclk),
    .rst_n       (rst_n),
    .i_sen_n     (i_sen_n),
    .i_sda       (i_sda),
    .o_sdo       (o_sdo),
    .o_sdo_oe    (o_sdo_oe),
    .o_wr_toggle (o_wr_toggle),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .i_dbg_addr  (i_dbg_addr),
    .o_dbg_data  (o_dbg_data)
  );

  always #5 o_sclk = ~o_sclk;

  always @(posedge o_wr_toggle or negedge o_wr_toggle) tog_edges++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  function automatic logic [7:0] exp_default(input int a);
    case (a)
      8'h01:   return 8'h40;
      8'h03:   return 8'h02;
      8'h12:   return 8'h5A;
      8'h1F:   return 8'h08;
      8'h20:   return 8'hC3;
      8'h7F:   return 8'h81;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dbg_rd(input logic [6:0] a, output logic [7:0] d);
    i_dbg_addr = a;
    #1;
    d = o_dbg_data;
  endtask

  // Master side: drive on falling edges, sample on rising edges; optionally keep select low.
  task automatic xfer(input logic [15:0] w, input int nbits, input bit keep_sel,
                      output logic [7:0] rd, output int oe_cnt);
    rd = 8'h00;
    oe_cnt = 0;
    if (i_sen_n) begin
      @(negedge o_sclk);
      #1;
      i_sen_n = 1'b0;
    end
    i_sda = w[15];
    for (int i = 0; i < nbits; i++) begin
      @(posedge o_sclk);
      #1;
      if (i >= 8) rd[15-i] = o_sdo;
      @(negedge o_sclk);
      #1;
      if (o_sdo_oe) oe_cnt++;
      if (i < 15) i_sda = w[14-i];
    end
    if (!keep_sel) i_sen_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge o_sclk);
    #1;
  endtask

  initial begin
    logic [7:0]  d;
    logic [7:0]  rd;
    logic [14:0] rec;
    int          oe;
    int          t0;

    rst_n = 1'b0;
    i_sen_n = 1'b1;
    i_sda = 1'b0;
    i_dbg_addr = 7'h00;
    idle(3);
    chk("rst_sdo", 32'(o_sdo), 32'h0);
    chk("rst_sdo_oe", 32'(o_sdo_oe), 32'h0);
    chk("rst_toggle", 32'(o_wr_toggle), 32'h0);
    chk("rst_wr_addr", 32'(o_wr_addr), 32'h0);
    chk("rst_wr_data", 32'(o_wr_data), 32'h0);
    rst_n = 1'b1;
    idle(2);

    for (int a = 0; a < 128; a++) begin
      dbg_rd(7'(a), d);
      chk($sformatf("dflt_%02h", a), 32'(d), 32'(exp_default(a)));
    end
    dbg_rd(7'h1F, d);
    chk("chip_id_dbg", 32'(d), 32'h08);

    // Plain write 0x12 <= 0x34
    t0 = tog_edges;
    wr_q.push_back({7'h12, 8'h34});
    xfer(16'h1234, 16, 1'b0, rd, oe);
    rec = wr_q.pop_front();
    chk("w1234_wr_addr", 32'(o_wr_addr), 32'(rec[14:8]));
    chk("w1234_wr_data", 32'(o_wr_data), 32'(rec[7:0]));
    chk("w1234_toggle", 32'(o_wr_toggle), 32'h1);
    chk("w1234_tog_edges", 32'(tog_edges - t0), 32'd1);
    chk("w1234_oe", 32'(oe), 32'd0);
    dbg_rd(7'h12, d);
    chk("w1234_rf", 32'(d), 32'h34);
    idle(2);

    // Reads: 0x12 then chip ID
    rd_q.push_back(8'h34);
    xfer(16'h9200, 16, 1'b0, rd, oe);
    chk("r12_data", 32'(rd), 32'(rd_q.pop_front()));
    chk("r12_oe_cnt", 32'(oe), 32'd8);
    chk("r12_oe_after", 32'(o_sdo_oe), 32'h0);
    idle(2);
    rd_q.push_back(8'h08);
    xfer(16'h9F00, 16, 1'b0, rd, oe);
    chk("r1f_data", 32'(rd), 32'(rd_q.pop_front()));
    chk("r1f_oe_cnt", 32'(oe), 32'd8);
    idle(2);

    // Back-to-back writes under one select
    t0 = tog_edges;
    wr_q.push_back({7'h05, 8'h55});
    wr_q.push_back({7'h06, 8'hAA});
    xfer(16'h0555, 16, 1'b1, rd, oe);
    rec = wr_q.pop_front();
    chk("b2b1_wr_addr", 32'(o_wr_addr), 32'(rec[14:8]));
    chk("b2b1_wr_data", 32'(o_wr_data), 32'(rec[7:0]));
    xfer(16'h06AA, 16, 1'b0, rd, oe);
    rec = wr_q.pop_front();
    chk("b2b2_wr_addr", 32'(o_wr_addr), 32'(rec[14:8]));
    chk("b2b2_wr_data", 32'(o_wr_data), 32'(rec[7:0]));
    chk("b2b_tog_edges", 32'(tog_edges - t0), 32'd2);
    chk("b2b_toggle", 32'(o_wr_toggle), 32'h1);
    dbg_rd(7'h05, d);
    chk("b2b_rf05", 32'(d), 32'h55);
    dbg_rd(7'h06, d);
    chk("b2b_rf06", 32'(d), 32'hAA);
    idle(2);

    // Aborted write, aborted read, then a clean read
    t0 = tog_edges;
    xfer(16'h20FF, 10, 1'b0, rd, oe);
    idle(2);
    dbg_rd(7'h20, d);
    chk("abort_rf20", 32'(d), 32'hC3);
    chk("abort_tog", 32'(tog_edges - t0), 32'd0);
    chk("abort_wr_addr", 32'(o_wr_addr), 32'h06);
    xfer(16'h9200, 11, 1'b1, rd, oe);
    chk("rabort_oe_pre", 32'(o_sdo_oe), 32'h1);
    i_sen_n = 1'b1;
    #1;
    chk("rabort_oe_rel", 32'(o_sdo_oe), 32'h0);
    idle(2);
    rd_q.push_back(8'hC3);
    xfer(16'hA000, 16, 1'b0, rd, oe);
    chk("post_abort_rd", 32'(rd), 32'(rd_q.pop_front()));
    chk("post_abort_oe", 32'(oe), 32'd8);
    idle(2);

    // Write to the read-only chip ID location
    t0 = tog_edges;
    xfer(16'h1F00, 16, 1'b0, rd, oe);
    idle(2);
    chk("wid_tog", 32'(tog_edges - t0), 32'd0);
    chk("wid_wr_addr", 32'(o_wr_addr), 32'h06);
    chk("wid_wr_data", 32'(o_wr_data), 32'hAA);
    rd_q.push_back(8'h08);
    xfer(16'h9F00, 16, 1'b0, rd, oe);
    chk("wid_rd", 32'(rd), 32'(rd_q.pop_front()));
    idle(2);

    // Soft reset through register 0x00 bit 5
    t0 = tog_edges;
    wr_q.push_back({7'h00, 8'h20});
    xfer(16'h0020, 16, 1'b0, rd, oe);
    idle(3);
    rec = wr_q.pop_front();
    chk("srst_tog", 32'(tog_edges - t0), 32'd1);
    chk("srst_wr_addr", 32'(o_wr_addr), 32'(rec[14:8]));
    chk("srst_wr_data", 32'(o_wr_data), 32'(rec[7:0]));
    dbg_rd(7'h12, d);
    chk("srst_rf12", 32'(d), 32'h5A);
    dbg_rd(7'h05, d);
    chk("srst_rf05", 32'(d), 32'h00);
    dbg_rd(7'h00, d);
    chk("srst_rf00_bit5", 32'(d[5]), 32'h0);
    rd_q.push_back(8'h5A);
    xfer(16'h9200, 16, 1'b0, rd, oe);
    chk("srst_rd12", 32'(rd), 32'(rd_q.pop_front()));
    idle(2);

    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
